// File: rtl/gshare_pht_pkg.sv
// gshare_pht_pkg: shared counter encoding, reset value and index hash for the gshare predictor
package gshare_pht_pkg;
  localparam int BRANCH_HISTORY_REG_SZ = 4;
  typedef logic [1:0] pht_ctr_t;
  localparam pht_ctr_t PHT_SNT = 2'b00;
  localparam pht_ctr_t PHT_WNT = 2'b01;
  localparam pht_ctr_t PHT_WT = 2'b10;
  localparam pht_ctr_t PHT_ST = 2'b11;
  localparam pht_ctr_t PHT_RESET_CTR = PHT_WNT;
  // Callers truncate to their history width, leaving pc[W+1:2] ^ bhr.
  function automatic logic [31:0] pht_hash(input logic [31:0] pc, input logic [31:0] bhr);
    return {2'b00, pc[31:2]} ^ bhr;
  endfunction
endpackage

// File: rtl/gshare_pht_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating up/down counter
// ports: ctr current value, inc count up when 1 else down, ctr_next saturated result
module sat_counter2
  import gshare_pht_pkg::*;
(
  input  pht_ctr_t ctr,
  input  logic     inc,
  output pht_ctr_t ctr_next
);
  always_comb
    ctr_next = inc ? ((ctr == PHT_ST) ? PHT_ST : ctr + 2'd1)
                   : ((ctr == PHT_SNT) ? PHT_SNT : ctr - 2'd1);
endmodule

// File: rtl/gshare_pht.sv
// gshare_pht: gshare pattern history table with combinational lookup, trained update and perf counters
// ports: clock/reset_n; lookup_pc/lookup_bhr -> pred_taken/pred_idx (combinational);
//        upd_valid/upd_pc/upd_bhr/upd_taken/upd_pred_taken train one counter per cycle;
//        perf_updates/perf_mispredicts are saturating registered counts
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int BHR_SZ = BRANCH_HISTORY_REG_SZ,
  parameter int PHT_ENTRIES = 2 ** BHR_SZ,
  parameter int PERF_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       lookup_pc,
  input  logic [BHR_SZ-1:0] lookup_bhr,
  output logic              pred_taken,
  output logic [BHR_SZ-1:0] pred_idx,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [BHR_SZ-1:0] upd_bhr,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispredicts
);
  pht_ctr_t pht_q [PHT_ENTRIES];
  logic [BHR_SZ-1:0] upd_idx;
  pht_ctr_t upd_ctr_next;
  logic mispredict;
  always_comb begin
    pred_idx = BHR_SZ'(pht_hash(lookup_pc, 32'(lookup_bhr)));
    upd_idx = BHR_SZ'(pht_hash(upd_pc, 32'(upd_bhr)));
    pred_taken = pht_q[pred_idx][1];
    mispredict = upd_taken != upd_pred_taken;
  end
  sat_counter2 u_sat (
    .ctr(pht_q[upd_idx]),
    .inc(upd_taken),
    .ctr_next(upd_ctr_next)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_RESET_CTR;
      perf_updates <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      pht_q[upd_idx] <= upd_ctr_next;
      perf_updates <= &perf_updates ? perf_updates : perf_updates + PERF_W'(1);
      if (mispredict)
        perf_mispredicts <= &perf_mispredicts ? perf_mispredicts : perf_mispredicts + PERF_W'(1);
    end
endmodule

// File: tb/tb_gshare_pht.sv
// tb_gshare_pht: directed self-checking bench for gshare_pht
module tb_gshare_pht;
  logic clock = 0;
  logic reset_n = 0;
  logic [31:0] lookup_pc = 0;
  logic [3:0] lookup_bhr = 0;
  logic pred_taken, pred_taken_s;
  logic [3:0] pred_idx, pred_idx_s;
  logic upd_valid = 0;
  logic [31:0] upd_pc = 0;
  logic [3:0] upd_bhr = 0;
  logic upd_taken = 0;
  logic upd_pred_taken = 0;
  logic [31:0] perf_updates, perf_mispredicts;
  logic [3:0] perf_updates_s, perf_mispredicts_s;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  gshare_pht #(.BHR_SZ(4), .PERF_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .lookup_pc(lookup_pc), .lookup_bhr(lookup_bhr),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_bhr(upd_bhr), .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .perf_updates(perf_updates), .perf_mispredicts(perf_mispredicts)
  );

  gshare_pht #(.BHR_SZ(4), .PERF_W(4)) dut_s (
    .clock(clock), .reset_n(reset_n), .lookup_pc(lookup_pc), .lookup_bhr(lookup_bhr),
    .pred_taken(pred_taken_s), .pred_idx(pred_idx_s), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_bhr(upd_bhr), .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .perf_updates(perf_updates_s), .perf_mispredicts(perf_mispredicts_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic [3:0] bhr);
    lookup_pc = pc;
    lookup_bhr = bhr;
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [3:0] bhr, input logic t, input logic pt);
    upd_pc = pc;
    upd_bhr = bhr;
    upd_taken = t;
    upd_pred_taken = pt;
    upd_valid = 1;
    @(posedge clock);
    #1;
    upd_valid = 0;
  endtask

  task automatic chk_perf(input string tag, input int u, input int m, input int us, input int ms);
    chk({tag, "_upd"}, perf_updates, 32'(u));
    chk({tag, "_mis"}, perf_mispredicts, 32'(m));
    chk({tag, "_upd_s"}, 32'(perf_updates_s), 32'(us));
    chk({tag, "_mis_s"}, 32'(perf_mispredicts_s), 32'(ms));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_perf("rst_hold", 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 16; i++) begin
      look(32'(i) << 2, 4'h0);
      chk("rst_idx", 32'(pred_idx), 32'(i));
      chk("rst_pred", 32'(pred_taken), 0);
    end
    chk_perf("rst", 0, 0, 0, 0);
    // training at idx 4: 01 -> 10 -> 11 -> 11 (sat) -> 10 -> 01
    look(32'h10, 4'h0);
    chk("trn_idx", 32'(pred_idx), 4);
    chk("trn_p0", 32'(pred_taken), 0);
    do_upd(32'h10, 4'h0, 1, 0);
    chk("trn_p1", 32'(pred_taken), 1);
    do_upd(32'h10, 4'h0, 1, 1);
    chk("trn_p2", 32'(pred_taken), 1);
    do_upd(32'h10, 4'h0, 1, 1);
    do_upd(32'h10, 4'h0, 1, 1);
    chk("trn_sat", 32'(pred_taken), 1);
    chk_perf("trn4", 4, 1, 4, 1);
    do_upd(32'h10, 4'h0, 0, 1);
    chk("trn_nt1", 32'(pred_taken), 1);
    do_upd(32'h10, 4'h0, 0, 1);
    chk("trn_nt2", 32'(pred_taken), 0);
    chk_perf("trn6", 6, 3, 6, 3);
    // aliasing: both map to idx 5
    look(32'h14, 4'h0);
    chk("ali_idx_a", 32'(pred_idx), 5);
    chk("ali_pa0", 32'(pred_taken), 0);
    look(32'h10, 4'h1);
    chk("ali_idx_b", 32'(pred_idx), 5);
    chk("ali_pb0", 32'(pred_taken), 0);
    do_upd(32'h14, 4'h0, 1, 1);
    do_upd(32'h14, 4'h0, 1, 1);
    look(32'h10, 4'h1);
    chk("ali_pb1", 32'(pred_taken), 1);
    look(32'h14, 4'h0);
    chk("ali_pa1", 32'(pred_taken), 1);
    // same-cycle collision at idx 7
    look(32'h1C, 4'h0);
    chk("col_idx", 32'(pred_idx), 7);
    upd_pc = 32'h1C;
    upd_bhr = 4'h0;
    upd_taken = 1;
    upd_pred_taken = 1;
    upd_valid = 1;
    #1;
    chk("col_same", 32'(pred_taken), 0);
    @(posedge clock);
    #1;
    upd_valid = 0;
    chk("col_next", 32'(pred_taken), 1);
    chk_perf("col", 9, 3, 9, 3);
    // async reset mid-cycle with an update pending
    upd_pc = 32'h14;
    upd_bhr = 4'h0;
    upd_taken = 0;
    upd_pred_taken = 1;
    upd_valid = 1;
    look(32'h1C, 4'h0);
    chk("ar_pre", 32'(pred_taken), 1);
    reset_n = 0;
    #1;
    chk("ar_pred", 32'(pred_taken), 0);
    chk_perf("ar", 0, 0, 0, 0);
    @(negedge clock);
    upd_valid = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    look(32'h14, 4'h0);
    chk("ar_idx5", 32'(pred_taken), 0);
    look(32'h10, 4'h0);
    chk("ar_idx4", 32'(pred_taken), 0);
    chk_perf("ar_rel", 0, 0, 0, 0);
    // perf: 10 updates, 3 mispredicts
    for (int i = 0; i < 10; i++) begin
      logic t;
      t = 1'(i & 1);
      do_upd(32'(i) << 2, 4'h3, t, (i == 2 || i == 5 || i == 8) ? ~t : t);
    end
    chk_perf("perf10", 10, 3, 10, 3);
    for (int i = 0; i < 10; i++) do_upd(32'(i) << 2, 4'h0, 1, 0);
    chk_perf("perf20", 20, 13, 15, 13);
    for (int i = 0; i < 5; i++) do_upd(32'h40, 4'h0, 0, 1);
    chk_perf("perf25", 25, 18, 15, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
